// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative HI/LO divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ZERO,
    RUN,
    DONE
  } state_t;

  localparam logic OP_DIVU = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Widest operand cond_neg handles; callers zero-extend in and truncate out.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                input logic             neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step
  #(parameter int WIDTH = 32)
  (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
  );

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;
  logic           borrow;

  always_comb begin
    partial = {rem_in, quo_in[WIDTH-1]};
    // WIDTH+1-bit subtract; the extra carry-out bit is the borrow.
    {borrow, diff} = {1'b0, partial} - {2'b00, divisor};
    rem_out = borrow ? partial[WIDTH-1:0] : WIDTH'(diff);
    quo_out = {quo_in[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU engine for the EX stage: quotient to LO, remainder to HI,
// stalling the pipeline until the registered result is available.
module div_unit
  #(parameter int WIDTH = 32)
  (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic             annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
  );

  import div_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic             q_neg, r_neg;
  logic             accept, last, is_div;
  logic             dvd_sign, dsr_sign;

  assign is_div   = (signed_op == OP_DIV);
  assign dvd_sign = is_div & dividend[WIDTH-1];
  assign dsr_sign = is_div & divisor[WIDTH-1];
  assign accept   = (state == IDLE) && start && !annul;
  assign last     = (count == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dsr_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (divisor == '0) ? ZERO : RUN;
      ZERO: state_nx = annul ? IDLE : DONE;
      RUN: begin
        if (annul)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: if (!start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign stall_req = accept || (state == RUN) || (state == ZERO);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
            quo_q <= WIDTH'(cond_neg(MAX_W'(dividend), dvd_sign));
            dsr_q <= WIDTH'(cond_neg(MAX_W'(divisor), dsr_sign));
            rem_q <= '0;
            count <= '0;
            q_neg <= dvd_sign ^ dsr_sign;
            r_neg <= dvd_sign;
          end
        end
        ZERO: begin
          if (!annul) begin
            quotient  <= '0;
            remainder <= '0;
          end
        end
        RUN: begin
          if (!annul) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            count <= count + 1'b1;
            if (last) begin
              quotient  <= WIDTH'(cond_neg(MAX_W'(quo_nx), q_neg));
              remainder <= WIDTH'(cond_neg(MAX_W'(rem_nx), r_neg));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: 32-bit and 8-bit instances checked against a longint reference.
module tb_div_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        start32 = 1'b0, sgn32 = 1'b0, annul32 = 1'b0;
  logic [31:0] dvd32 = '0, dsr32 = '0;
  logic        stall32, done32;
  logic [31:0] q32, r32;

  logic        start8 = 1'b0, sgn8 = 1'b0, annul8 = 1'b0;
  logic [7:0]  dvd8 = '0, dsr8 = '0;
  logic        stall8, done8;
  logic [7:0]  q8, r8;

  int vectors = 0;
  int miscompares = 0;

  bit          sel8 = 1'b0;
  logic        obs_stall, obs_done;
  logic [31:0] obs_q, obs_r;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) u_div32 (
    .clk(clk), .reset(reset), .start(start32), .signed_op(sgn32), .annul(annul32),
    .dividend(dvd32), .divisor(dsr32), .stall_req(stall32), .done(done32),
    .quotient(q32), .remainder(r32)
  );

  div_unit #(.WIDTH(8)) u_div8 (
    .clk(clk), .reset(reset), .start(start8), .signed_op(sgn8), .annul(annul8),
    .dividend(dvd8), .divisor(dsr8), .stall_req(stall8), .done(done8),
    .quotient(q8), .remainder(r8)
  );

  always_comb begin
    obs_stall = sel8 ? stall8 : stall32;
    obs_done  = sel8 ? done8  : done32;
    obs_q     = sel8 ? {24'b0, q8} : q32;
    obs_r     = sel8 ? {24'b0, r8} : r32;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input int w, input bit sgn, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] q,
                                output logic [31:0] r);
    longint m, sa, sbv, qq, rr;
    m   = (longint'(1) << w) - 1;
    sa  = longint'(a) & m;
    sbv = longint'(b) & m;
    if (sgn && sa[w-1])  sa  = sa  - (longint'(1) << w);
    if (sgn && sbv[w-1]) sbv = sbv - (longint'(1) << w);
    if (sbv == 0) begin
      qq = 0;
      rr = 0;
    end else begin
      qq = sa / sbv;
      rr = sa % sbv;
    end
    q = 32'(qq & m);
    r = 32'(rr & m);
  endfunction

  task automatic drive(input bit st, input bit sgn, input bit an,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel8) begin
      start8 = st; sgn8 = sgn; annul8 = an; dvd8 = a[7:0]; dsr8 = b[7:0];
    end else begin
      start32 = st; sgn32 = sgn; annul32 = an; dvd32 = a; dsr32 = b;
    end
  endtask

  task automatic do_op(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t        e, got_e;
    int          cyc, stalls, w;
    logic [31:0] bm;
    w  = w8 ? 8 : 32;
    bm = w8 ? {24'b0, b[7:0]} : b;
    model(w, sgn, a, b, e.q, e.r);
    e.lat = (bm == 0) ? 2 : w + 1;
    sb.push_back(e);
    sel8 = w8;
    @(negedge clk);
    drive(1'b1, sgn, 1'b0, a, b);
    #1 check_eq("stall_on_request", obs_stall, 1);
    cyc = 0;
    stalls = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (obs_stall) stalls++;
    end while (!obs_done && cyc < 100);
    check_eq("done_seen", obs_done, 1);
    got_e = sb.pop_front();
    check_eq("latency", cyc, got_e.lat);
    check_eq("stall_cycles", stalls, got_e.lat - 1);
    check_eq("stall_in_done", obs_stall, 0);
    check_eq("quotient", obs_q, got_e.q);
    check_eq("remainder", obs_r, got_e.r);
    drive(1'b1, ~sgn, 1'b1, ~a, b + 1);
    @(negedge clk);
    check_eq("done_held", obs_done, 1);
    check_eq("quotient_stable", obs_q, got_e.q);
    check_eq("remainder_stable", obs_r, got_e.r);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_eq("done_drop", obs_done, 0);
    check_eq("stall_idle", obs_stall, 0);
  endtask

  initial begin
    logic [31:0] prev_q, prev_r;
    int          seen;

    repeat (2) @(negedge clk);
    check_eq("reset_done", done32, 0);
    check_eq("reset_stall", stall32, 0);
    check_eq("reset_q", q32, 0);
    check_eq("reset_r", r32, 0);
    check_eq("reset_q8", {24'b0, q8}, 0);
    reset = 1'b1;

    do_op(1'b0, 1'b0, 32'd100, 32'd7);
    do_op(1'b0, 1'b1, -32'sd7, 32'd2);
    do_op(1'b0, 1'b1, 32'd7, -32'sd2);
    do_op(1'b0, 1'b1, 32'd5, 32'd0);
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    do_op(1'b0, 1'b0, 32'd3, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++)
      do_op(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom >> $urandom_range(0, 28));

    // annul 10 cycles into a running divide; outputs must keep the last result
    sel8 = 1'b0;
    prev_q = q32;
    prev_r = r32;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
    repeat (11) @(negedge clk);
    annul32 = 1'b1;
    @(negedge clk);
    check_eq("annul_done", done32, 0);
    check_eq("annul_stall", stall32, 0);
    check_eq("annul_q_kept", q32, prev_q);
    check_eq("annul_r_kept", r32, prev_r);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) seen++;
    end
    check_eq("annul_no_done", seen, 0);
    do_op(1'b0, 1'b0, 32'd9, 32'd3);

    // synchronous reset in the middle of RUN
    sel8 = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    start32 = 1'b0;
    @(negedge clk);
    check_eq("midrst_done", done32, 0);
    check_eq("midrst_q", q32, 0);
    check_eq("midrst_r", r32, 0);
    check_eq("midrst_stall", stall32, 0);
    reset = 1'b1;
    do_op(1'b0, 1'b0, 32'd1234, 32'd10);

    do_op(1'b1, 1'b1, 32'h80, 32'hFF);
    do_op(1'b1, 1'b0, 32'hFF, 32'h10);
    do_op(1'b1, 1'b1, 32'h81, 32'h00);
    do_op(1'b1, 1'b1, 32'hF9, 32'h02);
    for (int i = 0; i < 6; i++)
      do_op(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);

    check_eq("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
